// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: access size codes and FSM states.
package data_mem_ctrl_pkg;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRmwRd = 2'd1,
      StRmwWr = 2'd2
   } state_t;

   function automatic logic is_reserved(input logic [2:0] size);
      return (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: load byte/half extract with sign/zero extension, and store merge.
module byte_lane_unit
   import data_mem_ctrl_pkg::*;
(
   input  logic [31:0] i_ld_word,
   input  logic [2:0]  i_ld_size,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_st_word,
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_ld_data,
   output logic [31:0] o_st_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_ld_off)
         2'd0:    w_byte = i_ld_word[7:0];
         2'd1:    w_byte = i_ld_word[15:8];
         2'd2:    w_byte = i_ld_word[23:16];
         default: w_byte = i_ld_word[31:24];
      endcase
      w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

      case (i_ld_size)
         MEM_B:   o_ld_data = {{24{w_byte[7]}}, w_byte};
         MEM_H:   o_ld_data = {{16{w_half[15]}}, w_half};
         MEM_BU:  o_ld_data = {24'h0, w_byte};
         MEM_HU:  o_ld_data = {16'h0, w_half};
         default: o_ld_data = i_ld_word;
      endcase
   end

   always_comb begin
      o_st_merged = i_st_word;
      case (i_st_size)
         2'b00: begin
            case (i_st_off)
               2'd0:    o_st_merged[7:0]   = i_st_data[7:0];
               2'd1:    o_st_merged[15:8]  = i_st_data[7:0];
               2'd2:    o_st_merged[23:16] = i_st_data[7:0];
               default: o_st_merged[31:24] = i_st_data[7:0];
            endcase
         end
         2'b01: begin
            if (i_st_off[1]) o_st_merged[31:16] = i_st_data[15:0];
            else             o_st_merged[15:0]  = i_st_data[15:0];
         end
         default: o_st_merged = i_st_data;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-port word RAM with byte/half loads and read-modify-write
// sub-word stores.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 2048,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_wr,
   input  logic [2:0]  mem_size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0] r_ram [DEPTH_WORDS];

   state_t      r_state, w_state_d;
   logic        r_err, w_err_d;
   logic [31:0] r_ld_word;
   logic [2:0]  r_ld_size;
   logic [1:0]  r_ld_off;
   logic [AW-1:0] r_st_idx;
   logic [31:0] r_st_wdata;
   logic [1:0]  r_st_size;
   logic [1:0]  r_st_off;
   logic [31:0] r_rmw_word;

   logic [AW-1:0] w_idx, w_ram_idx;
   logic [31:0] w_ram_wdata, w_ld_data, w_merged;
   logic        w_ram_we, w_ld_acc, w_ld_mis, w_st_lat, w_rmw_rd;
   logic        w_reserved, w_misalign;
   logic        w_unused_addr;

   // Upper address bits alias onto the RAM.
   assign w_idx         = addr[AW+1:2];
   assign w_unused_addr = ^addr[31:AW+2];
   assign w_reserved    = is_reserved(mem_size);
   assign w_misalign    = ((mem_size[1:0] == 2'b01) && addr[0]) ||
                          ((mem_size[1:0] == 2'b10) && (addr[1:0] != 2'b00));

   byte_lane_unit u_lanes (
      .i_ld_word   (r_ld_word),
      .i_ld_size   (r_ld_size),
      .i_ld_off    (r_ld_off),
      .i_st_word   (r_rmw_word),
      .i_st_size   (r_st_size),
      .i_st_off    (r_st_off),
      .i_st_data   (r_st_wdata),
      .o_ld_data   (w_ld_data),
      .o_st_merged (w_merged)
   );

   always_comb begin
      w_state_d   = r_state;
      w_err_d     = 1'b0;
      w_ram_we    = 1'b0;
      w_ram_idx   = w_idx;
      w_ram_wdata = wdata;
      w_ld_acc    = 1'b0;
      w_ld_mis    = 1'b0;
      w_st_lat    = 1'b0;
      w_rmw_rd    = 1'b0;
      case (r_state)
         StIdle: begin
            if (mem_en) begin
               if (w_reserved || w_misalign) begin
                  w_err_d  = 1'b1;
                  w_ld_mis = !mem_wr && !w_reserved;
               end else if (!mem_wr) begin
                  w_ld_acc = 1'b1;
               end else if (mem_size[1:0] == 2'b10) begin
                  w_ram_we = 1'b1;
               end else begin
                  w_st_lat  = 1'b1;
                  w_state_d = StRmwRd;
               end
            end
         end
         StRmwRd: begin
            w_ram_idx = r_st_idx;
            w_rmw_rd  = 1'b1;
            w_err_d   = mem_en;
            w_state_d = StRmwWr;
         end
         StRmwWr: begin
            w_ram_idx   = r_st_idx;
            w_ram_we    = 1'b1;
            w_ram_wdata = w_merged;
            w_err_d     = mem_en;
            w_state_d   = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
      // Reset abandons any in-flight store without touching RAM.
      if (!rst) w_ram_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_idx] <= w_ram_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_err      <= 1'b0;
         r_ld_word  <= 32'h0;
         r_ld_size  <= 3'b000;
         r_ld_off   <= 2'b00;
         r_st_idx   <= '0;
         r_st_wdata <= 32'h0;
         r_st_size  <= 2'b00;
         r_st_off   <= 2'b00;
         r_rmw_word <= 32'h0;
      end else begin
         r_state <= w_state_d;
         r_err   <= w_err_d;
         if (w_ld_acc) begin
            r_ld_word <= r_ram[w_ram_idx];
            r_ld_size <= mem_size;
            r_ld_off  <= addr[1:0];
         end else if (w_ld_mis) begin
            r_ld_word <= 32'h0;
         end
         if (w_st_lat) begin
            r_st_idx   <= w_idx;
            r_st_wdata <= wdata;
            r_st_size  <= mem_size[1:0];
            r_st_off   <= addr[1:0];
         end
         if (w_rmw_rd) r_rmw_word <= r_ram[w_ram_idx];
      end
   end

   assign rdata = w_ld_data;
   assign busy  = (r_state != StIdle);
   assign err   = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a load-result scoreboard queue.
module tb_data_mem_ctrl;
   import data_mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_en = 1'b0;
   logic        mem_wr = 1'b0;
   logic [2:0]  mem_size = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        busy;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] q_exp [$];

   data_mem_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .mem_en   (mem_en),
      .mem_wr   (mem_wr),
      .mem_size (mem_size),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
      mem_en   = en;
      mem_wr   = wr;
      mem_size = sz;
      addr     = a;
      wdata    = d;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      drive(1'b1, 1'b1, sz, a, d);
      cyc();
      mem_en = 1'b0;
   endtask

   task automatic load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] exp);
      logic [31:0] want;
      q_exp.push_back(exp);
      drive(1'b1, 1'b0, sz, a, 32'h0);
      cyc();
      mem_en = 1'b0;
      want = q_exp.pop_front();
      check(tag, rdata, want);
      check({tag, "_err"}, {31'h0, err}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(); cyc(); cyc();
      check("rst_rdata", rdata, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      rst = 1'b1;
      cyc();

      store(32'h10, 32'hDEADBEEF, MEM_W);
      check("sw_busy", {31'h0, busy}, 32'h0);
      check("sw_err", {31'h0, err}, 32'h0);
      load("lw_10", 32'h10, MEM_W, 32'hDEADBEEF);
      check("lw_busy", {31'h0, busy}, 32'h0);

      load("lb_13", 32'h13, MEM_B, 32'hFFFFFFDE);
      load("lbu_13", 32'h13, MEM_BU, 32'h000000DE);
      load("lh_10", 32'h10, MEM_H, 32'hFFFFBEEF);
      load("lhu_12", 32'h12, MEM_HU, 32'h0000DEAD);
      load("lb_10", 32'h10, MEM_B, 32'hFFFFFFEF);
      load("lbu_11", 32'h11, MEM_BU, 32'h000000BE);

      store(32'h11, 32'h00000055, MEM_B);
      check("sb_busy1", {31'h0, busy}, 32'h1);
      cyc();
      check("sb_busy2", {31'h0, busy}, 32'h1);
      cyc();
      check("sb_busy3", {31'h0, busy}, 32'h0);
      load("lw_after_sb", 32'h10, MEM_W, 32'hDEAD55EF);

      q_exp.push_back(32'h0);
      drive(1'b1, 1'b0, MEM_W, 32'h12, 32'h0);
      cyc();
      mem_en = 1'b0;
      check("mis_lw_err", {31'h0, err}, 32'h1);
      check("mis_lw_rdata", rdata, q_exp.pop_front());
      cyc();
      check("err_pulse_end", {31'h0, err}, 32'h0);
      store(32'h11, 32'h00001234, MEM_H);
      check("mis_sh_err", {31'h0, err}, 32'h1);
      check("mis_sh_busy", {31'h0, busy}, 32'h0);
      load("ram_unchanged", 32'h10, MEM_W, 32'hDEAD55EF);

      drive(1'b1, 1'b0, 3'b011, 32'h14, 32'h0);
      cyc();
      mem_en = 1'b0;
      check("rsv_err", {31'h0, err}, 32'h1);
      check("rsv_rdata_hold", rdata, 32'hDEAD55EF);

      store(32'h12, 32'h0000CAFE, MEM_H);
      check("sh_busy", {31'h0, busy}, 32'h1);
      drive(1'b1, 1'b0, MEM_W, 32'h30, 32'h11111111);
      cyc();
      mem_en = 1'b0;
      check("busy_drop_err", {31'h0, err}, 32'h1);
      check("busy_rdata_hold", rdata, 32'hDEAD55EF);
      cyc();
      check("sh_done_busy", {31'h0, busy}, 32'h0);
      load("lw_after_sh", 32'h10, MEM_W, 32'hCAFE55EF);

      store(32'h20, 32'h11223344, MEM_W);
      store(32'h20, 32'h000000AA, MEM_B);
      check("sb20_busy", {31'h0, busy}, 32'h1);
      rst = 1'b0;
      cyc();
      check("rmw_rst_busy", {31'h0, busy}, 32'h0);
      check("rmw_rst_err", {31'h0, err}, 32'h0);
      check("rmw_rst_rdata", rdata, 32'h0);
      cyc();
      rst = 1'b1;
      load("rmw_abandoned", 32'h20, MEM_W, 32'h11223344);

      load("wrap_alias", 32'h00002010, MEM_W, 32'hCAFE55EF);

      store(32'h30, 32'h0BADF00D, MEM_W);
      load("b2b_sw_lw", 32'h30, MEM_W, 32'h0BADF00D);

      store(32'h33, 32'h00000080, MEM_B);
      cyc();
      cyc();
      load("lb_33", 32'h33, MEM_B, 32'hFFFFFF80);
      load("lhu_32", 32'h32, MEM_HU, 32'h000080AD);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
